// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state, cause and vector definitions for pc_sequencer.
// Optional perf counter is enabled by PC_SEQ_PERF_EN in the top.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      TRAP_BUB
   } state_t;

   localparam logic [3:0]  CAUSE_MISALIGN = 4'd1;
   localparam logic [31:0] RESET_VECTOR   = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR    = 32'h0000_0080;

   function automatic logic misaligned(input logic [31:0] a);
      return a[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority next-PC select with misaligned-target trap detect.
// Purely combinational; the top decides when the result is used.
module pc_next_sel
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] epc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        eret,
   input  logic        trap_req,
   input  logic [3:0]  trap_cause_in,
   output logic [31:0] next_pc,
   output logic        take_trap,
   output logic [3:0]  trap_cause
);

   logic sel_jump;
   logic sel_branch;
   logic misalign;

   // Only the target that would actually win can fault.
   assign sel_jump   = !stall && !eret && jump;
   assign sel_branch = !stall && !eret && !jump && branch_taken;
   assign misalign   = (sel_jump && misaligned(jump_target))
                    || (sel_branch && misaligned(branch_target));

   always_comb begin
      next_pc    = pc + 32'd4;
      take_trap  = 1'b0;
      trap_cause = trap_cause_in;
      if (misalign) begin
         take_trap  = 1'b1;
         trap_cause = CAUSE_MISALIGN;
         next_pc    = TRAP_VECTOR;
      end else if (trap_req) begin
         take_trap  = 1'b1;
         next_pc    = TRAP_VECTOR;
      end else if (stall) begin
         next_pc    = pc;
      end else if (eret) begin
         next_pc    = epc;
      end else if (jump) begin
         next_pc    = jump_target;
      end else if (branch_taken) begin
         next_pc    = branch_target;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, boot/trap bubble FSM, epc/cause capture.
// Define PC_SEQ_PERF_EN to add the instret retired-fetch counter.
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        eret,
   input  logic        trap_req,
   input  logic [3:0]  trap_cause_in,
   output logic [31:0] pc_out,
   output logic        fetch_valid,
   output logic [31:0] epc,
   output logic [3:0]  cause,
   output logic        trap_ack
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0] instret
`endif
);

   state_t      state;
   logic [31:0] next_pc;
   logic        take_trap;
   logic [3:0]  trap_cause;

   pc_next_sel u_sel (
      .pc            (pc_out),
      .epc           (epc),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .eret          (eret),
      .trap_req      (trap_req),
      .trap_cause_in (trap_cause_in),
      .next_pc       (next_pc),
      .take_trap     (take_trap),
      .trap_cause    (trap_cause)
   );

   // State updates on the falling edge; requests outside RUN are dropped.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         pc_out      <= RESET_VECTOR;
         fetch_valid <= 1'b0;
         epc         <= 32'd0;
         cause       <= 4'd0;
         trap_ack    <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               pc_out <= next_pc;
               if (take_trap) begin
                  epc         <= pc_out;
                  cause       <= trap_cause;
                  trap_ack    <= 1'b1;
                  fetch_valid <= 1'b0;
                  state       <= TRAP_BUB;
               end else begin
                  trap_ack    <= 1'b0;
               end
            end
            BOOT, TRAP_BUB: begin
               state       <= RUN;
               fetch_valid <= 1'b1;
               trap_ack    <= 1'b0;
            end
            default: begin
               state       <= BOOT;
               fetch_valid <= 1'b0;
               trap_ack    <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_SEQ_PERF_EN
   always_ff @(negedge clk or negedge reset) begin
      if (!reset)
         instret <= 32'd0;
      else if (state == RUN && !stall && !take_trap)
         instret <= instret + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed walk plus random run against a reference model.
// Build with PC_SEQ_PERF_EN to also check instret.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        eret;
   logic        trap_req;
   logic [3:0]  trap_cause_in;
   logic [31:0] pc_out;
   logic        fetch_valid;
   logic [31:0] epc;
   logic [3:0]  cause;
   logic        trap_ack;
`ifdef PC_SEQ_PERF_EN
   logic [31:0] instret;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_epc;
   logic [3:0]  m_cause;
   logic        m_ack;
   logic [31:0] m_instret;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .eret          (eret),
      .trap_req      (trap_req),
      .trap_cause_in (trap_cause_in),
      .pc_out        (pc_out),
      .fetch_valid   (fetch_valid),
      .epc           (epc),
      .cause         (cause),
      .trap_ack      (trap_ack)
`ifdef PC_SEQ_PERF_EN
      ,
      .instret       (instret)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0;
      m_valid   = 1'b0;
      m_epc     = 32'h0;
      m_cause   = 4'h0;
      m_ack     = 1'b0;
      m_instret = 32'h0;
   endtask

   task automatic clear_inputs();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      jump_target   = 32'h0;
      eret          = 1'b0;
      trap_req      = 1'b0;
      trap_cause_in = 4'h0;
   endtask

   // One falling edge of the architectural rules.
   task automatic model_edge();
      logic [31:0] tgt;
      logic        has_tgt;
      logic        bad;
      if (!m_valid) begin
         m_valid = 1'b1;
         m_ack   = 1'b0;
         return;
      end
      m_ack   = 1'b0;
      has_tgt = 1'b0;
      tgt     = 32'h0;
      if (!stall && !eret) begin
         if (jump) begin
            has_tgt = 1'b1;
            tgt     = jump_target;
         end else if (branch_taken) begin
            has_tgt = 1'b1;
            tgt     = branch_target;
         end
      end
      bad = has_tgt && (tgt % 4 != 0);
      if (bad || trap_req) begin
         m_epc   = m_pc;
         m_cause = bad ? 4'd1 : trap_cause_in;
         m_pc    = 32'h80;
         m_valid = 1'b0;
         m_ack   = 1'b1;
      end else if (stall) begin
         m_pc = m_pc;
      end else begin
         m_instret = m_instret + 1;
         if (eret)         m_pc = m_epc;
         else if (has_tgt) m_pc = tgt;
         else              m_pc = m_pc + 4;
      end
   endtask

   task automatic compare_model();
      check("m_pc", pc_out, m_pc);
      check("m_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
      check("m_epc", epc, m_epc);
      check("m_cause", {28'b0, cause}, {28'b0, m_cause});
      check("m_ack", {31'b0, trap_ack}, {31'b0, m_ack});
`ifdef PC_SEQ_PERF_EN
      check("m_instret", instret, m_instret);
`endif
   endtask

   // Advance one cycle; returns just after the rising edge.
   task automatic tick();
      @(negedge clk);
      model_edge();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   initial begin
      logic [31:0] snap;
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", pc_out, 32'h0);
      check("rst_valid", {31'b0, fetch_valid}, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_cause", {28'b0, cause}, 32'h0);
      check("rst_ack", {31'b0, trap_ack}, 32'h0);
      reset = 1'b1;
      #1;
      check("boot_valid", {31'b0, fetch_valid}, 32'h0);

      tick();
      check("first_pc", pc_out, 32'h0);
      check("first_valid", {31'b0, fetch_valid}, 32'h1);
      tick(); check("seq_4", pc_out, 32'h4);
      tick(); check("seq_8", pc_out, 32'h8);
      tick(); check("seq_c", pc_out, 32'hC);
      tick(); check("seq_10", pc_out, 32'h10);

      stall = 1; jump = 1; jump_target = 32'h40;
      branch_taken = 1; branch_target = 32'h20;
      tick(); check("stall_hold", pc_out, 32'h10);
      stall = 0;
      tick(); check("jump_wins", pc_out, 32'h40);
      clear_inputs();
      jump = 1; jump_target = 32'h24;
      tick(); check("jump_24", pc_out, 32'h24);
      clear_inputs();

      trap_req = 1; trap_cause_in = 4'd3;
      tick();
      check("trap_pc", pc_out, 32'h80);
      check("trap_epc", epc, 32'h24);
      check("trap_cause", {28'b0, cause}, 32'd3);
      check("trap_ack", {31'b0, trap_ack}, 32'h1);
      check("trap_valid", {31'b0, fetch_valid}, 32'h0);
      tick();
      check("bub_pc", pc_out, 32'h80);
      check("bub_ack", {31'b0, trap_ack}, 32'h0);
      check("bub_valid", {31'b0, fetch_valid}, 32'h1);
      clear_inputs();
      tick(); check("vec_84", pc_out, 32'h84);
      eret = 1;
      tick(); check("eret_pc", pc_out, 32'h24);
      clear_inputs();

      branch_taken = 1; branch_target = 32'h102;
      tick();
      check("mis_pc", pc_out, 32'h80);
      check("mis_cause", {28'b0, cause}, 32'd1);
      check("mis_epc", epc, 32'h24);
      clear_inputs();
      tick();
      jump = 1; jump_target = 32'hFFFF_FFFC;
      tick(); check("top_pc", pc_out, 32'hFFFF_FFFC);
      clear_inputs();
      tick(); check("wrap_pc", pc_out, 32'h0);

`ifdef PC_SEQ_PERF_EN
      snap = instret;
`else
      snap = 32'h0;
`endif
      for (int i = 0; i < 7; i++) begin
         stall = (i == 2 || i == 5);
         tick();
      end
      stall = 0;
`ifdef PC_SEQ_PERF_EN
      check("instret_5", instret - snap, 32'd5);
`endif
      check("after_perf_pc", pc_out, 32'd20 + snap * 0);

      #2 reset = 1'b0;
      #1;
      model_reset();
      check("mid_rst_pc", pc_out, 32'h0);
      check("mid_rst_valid", {31'b0, fetch_valid}, 32'h0);
      @(posedge clk);
      reset = 1'b1;
      #1;

      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom % 4) == 0;
         trap_req      = ($urandom % 12) == 0;
         trap_cause_in = 4'($urandom);
         eret          = ($urandom % 10) == 0;
         jump          = ($urandom % 6) == 0;
         branch_taken  = ($urandom % 5) == 0;
         jump_target   = {$urandom, 2'b00} >> 2 << 2;
         branch_target = $urandom & 32'hFFFF_FFFC;
         if ($urandom % 8 == 0) jump_target[1:0] = 2'($urandom);
         if ($urandom % 8 == 0) branch_target[1:0] = 2'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
